// File: rtl/pid_pkg.sv
// Shared definitions for the time-shared PID multiplier: widths, FSM states and the saturating clamp.
package pid_pkg;

  localparam int W_DEF     = 6;
  localparam int SHIFT_DEF = 3;

  // Accumulator width: room for the sum of three exact W x W products plus sign.
  function automatic int acc_w(input int w);
    return 2 * w + 2;
  endfunction

  localparam int ACC_W = acc_w(W_DEF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_P = 3'd1,
    MUL_I = 3'd2,
    MUL_D = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/pid_serial_mult.sv
// Serial shift-add multiplier, LSB first, accumulating into a shared signed accumulator.
module pid_serial_mult
  import pid_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         step,
  input  logic                         clear,
  input  logic signed [W-1:0]          mcand,
  input  logic        [W-1:0]          mult,
  output logic signed [acc_w(W)-1:0]   acc_next
);

  localparam int AW = acc_w(W);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] mc;
  logic        [W-1:0]  g;

  // Next accumulator value; exported so the output can be formed on the final step edge.
  always_comb begin
    acc_next = acc;
    if (clear)
      acc_next = '0;
    else if (step && g[0])
      acc_next = acc + mc;
  end

  // Accumulator register, cleared by reset so an aborted sample leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else
      acc <= acc_next;
  end

  // Multiplicand/gain shifters; a load takes priority so the next term can start on the last step edge.
  always_ff @(posedge clk) begin
    if (load) begin
      mc <= {{(AW-W){mcand[W-1]}}, mcand};
      g  <= mult;
    end else if (step) begin
      mc <= mc <<< 1;
      g  <= g >> 1;
    end
  end

endmodule

// File: rtl/pid_mult_scheduler.sv
// PID sequencer: one serial multiplier shared across the P, I and D terms, summed, scaled and clamped.
module pid_mult_scheduler
  import pid_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic signed [W-1:0] e,
  input  logic        [W-1:0] K_p,
  input  logic        [W-1:0] K_i,
  input  logic        [W-1:0] K_d,
  output logic signed [W-1:0] u,
  output logic                u_valid,
  output logic                busy
);

  localparam int AW = acc_w(W);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 last, accept;
  logic                 load, step, clear, upd;
  logic signed [W-1:0]  mcand;
  logic        [W-1:0]  mult;
  logic signed [W-1:0]  e_sum, e_prev, e_diff;
  logic        [W-1:0]  ki_q, kd_q;
  logic signed [AW-1:0] acc_next;

  assign sample_ready = (state == IDLE) && ena;
  assign u_valid      = (state == DONE) && ena;
  assign busy         = (state != IDLE);
  assign accept       = sample_valid && sample_ready;
  assign last         = (cnt == CW'(W - 1));

  // Sequencing: each MUL state steps W times; the last step of P and I also loads the next operand pair.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;
    upd       = 1'b0;
    mcand     = e;
    mult      = K_p;
    if (ena) begin
      case (state)
        IDLE: if (sample_valid) begin
          state_nxt = MUL_P;
          cnt_nxt   = '0;
          load      = 1'b1;
          clear     = 1'b1;
        end
        MUL_P: begin
          step    = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (last) begin
            state_nxt = MUL_I;
            cnt_nxt   = '0;
            load      = 1'b1;
            mcand     = e_sum;
            mult      = ki_q;
          end
        end
        MUL_I: begin
          step    = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (last) begin
            state_nxt = MUL_D;
            cnt_nxt   = '0;
            load      = 1'b1;
            mcand     = e_diff;
            mult      = kd_q;
          end
        end
        MUL_D: begin
          step    = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (last) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
            upd       = 1'b1;
          end
        end
        DONE:    state_nxt = IDLE;
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Running integral, previous error and the clamped output (all cleared by reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_sum  <= '0;
      e_prev <= '0;
      u      <= '0;
    end else begin
      if (accept) begin
        e_sum  <= W'(sat_w(32'(e_sum) + 32'(e), W));
        e_prev <= e;
      end
      if (upd)
        u <= W'(sat_w(32'(acc_next >>> SHIFT), W));
    end
  end

  // Per-sample operands latched at accept; always written before being used.
  always_ff @(posedge clk) begin
    if (accept) begin
      e_diff <= W'(sat_w(32'(e) - 32'(e_prev), W));
      ki_q   <= K_i;
      kd_q   <= K_d;
    end
  end

  pid_serial_mult #(.W(W)) u_mult (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .clear    (clear),
    .mcand    (mcand),
    .mult     (mult),
    .acc_next (acc_next)
  );

endmodule

// File: tb/tb_pid_mult_scheduler.sv
// Bench for pid_mult_scheduler: fixed vectors, reset/stall sequences and random samples vs. a PID model.
module tb_pid_mult_scheduler;

  localparam int W = 6;

  logic                clk;
  logic                rst;
  logic                ena;
  logic                sample_valid;
  logic                sample_ready;
  logic signed [W-1:0] e;
  logic        [W-1:0] K_p, K_i, K_d;
  logic signed [W-1:0] u;
  logic                u_valid;
  logic                busy;

  int total = 0;
  int bad   = 0;

  // Reference state: integral and previous error, in plain integers.
  int m_esum  = 0;
  int m_eprev = 0;

  pid_mult_scheduler #(.W(W), .SHIFT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .e            (e),
    .K_p          (K_p),
    .K_i          (K_i),
    .K_d          (K_d),
    .u            (u),
    .u_valid      (u_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int satw(input int x);
    if (x > 31)  return 31;
    if (x < -32) return -32;
    return x;
  endfunction

  function automatic int floor_div8(input int x);
    if (x >= 0) return x / 8;
    return -((-x + 7) / 8);
  endfunction

  // PID reference: update integral/difference, form the gain-weighted sum, scale by 1/8 (floor), clamp.
  task automatic model_step(input int ev, input int kp, input int ki, input int kd, output int exp_u);
    int ediff;
    m_esum  = satw(m_esum + ev);
    ediff   = satw(ev - m_eprev);
    m_eprev = ev;
    exp_u   = satw(floor_div8(ev * kp + m_esum * ki + ediff * kd));
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_esum  = 0;
    m_eprev = 0;
  endtask

  // Offer one sample, scramble inputs after accept, optionally stall/hold valid, and measure the result.
  task automatic do_sample(input int ev, input int kp, input int ki, input int kd,
                           input int stall_at, input int stall_len, input bit hold,
                           input string nm, output int uo);
    int guard, lat, bcnt, rbad;
    guard = 0; lat = -1; bcnt = 0; rbad = 0; uo = 0;
    @(negedge clk);
    while (!sample_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!sample_ready) begin
      chk({nm, "_ready_timeout"}, 0, 1);
      return;
    end
    e = W'(ev); K_p = W'(kp); K_i = W'(ki); K_d = W'(kd);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    e   = W'($urandom);
    K_p = W'($urandom);
    K_i = W'($urandom);
    K_d = W'($urandom);
    for (int k = 1; k <= 80; k++) begin
      ena = !(k >= stall_at && k < stall_at + stall_len);
      if (hold) begin
        sample_valid = 1'b1;
        e = W'($urandom);
      end
      @(negedge clk);
      if (busy && sample_ready) rbad++;
      if (!ena && (sample_ready || u_valid)) rbad++;
      if (busy) bcnt++;
      if (u_valid) begin
        lat = k;
        uo  = int'(u);
        break;
      end
      @(posedge clk); #1;
    end
    chk({nm, "_latency"}, lat, 19 + stall_len);
    chk({nm, "_ready_while_busy"}, rbad, 0);
    if (lat >= 0) begin
      chk({nm, "_busy_cycles"}, bcnt, lat);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      ena = 1'b1;
      @(negedge clk);
      chk({nm, "_busy_after"}, int'(busy), 0);
      chk({nm, "_ready_after"}, int'(sample_ready), 1);
      chk({nm, "_u_hold"}, int'(u), uo);
    end
    sample_valid = 1'b0;
    ena = 1'b1;
  endtask

  typedef struct {
    bit do_rst;
    int ev;
    int kp;
    int ki;
    int kd;
    int exp_u;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int uo, mexp, pulses;
    int ev, kp, ki, kd, sa, sl;
    bit hold;

    tbl[0]  = '{1'b1,   5,  8, 0, 0,   5};
    tbl[1]  = '{1'b1,   3,  0, 8, 0,   3};
    tbl[2]  = '{1'b0,   3,  0, 8, 0,   6};
    tbl[3]  = '{1'b0,   3,  0, 8, 0,   9};
    tbl[4]  = '{1'b0,  31,  0, 8, 0,  31};
    tbl[5]  = '{1'b0,  31,  0, 8, 0,  31};
    tbl[6]  = '{1'b1,  10,  0, 0, 8,  10};
    tbl[7]  = '{1'b0, -10,  0, 0, 8, -20};
    tbl[8]  = '{1'b1,  31, 63, 0, 0,  31};
    tbl[9]  = '{1'b1, -32, 63, 0, 0, -32};
    tbl[10] = '{1'b0,   7,  5, 2, 3,   9};
    tbl[11] = '{1'b0, -20,  1, 1, 1, -10};

    rst = 1'b1; ena = 1'b1; sample_valid = 1'b0;
    e = '0; K_p = '0; K_i = '0; K_d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_u", int'(u), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_u_valid", int'(u_valid), 0);
    chk("reset_ready", int'(sample_ready), 1);
    ena = 1'b0;
    #1;
    chk("ena_low_ready", int'(sample_ready), 0);
    ena = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_rst) apply_reset();
      model_step(tbl[i].ev, tbl[i].kp, tbl[i].ki, tbl[i].kd, mexp);
      do_sample(tbl[i].ev, tbl[i].kp, tbl[i].ki, tbl[i].kd, 0, 0, 1'b0,
                $sformatf("vec%0d", i), uo);
      chk($sformatf("vec%0d_u", i), uo, tbl[i].exp_u);
    end

    // Reset in the middle of MUL_I: the sample is dropped and state is cleared at once.
    @(negedge clk);
    e = W'(20); K_p = W'(8); K_i = '0; K_d = '0;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("midrst_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_u", int'(u), 0);
    chk("midrst_u_valid", int'(u_valid), 0);
    chk("midrst_ready", int'(sample_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    m_esum = 0;
    m_eprev = 0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (u_valid) pulses++;
    end
    chk("midrst_no_u_valid", pulses, 0);
    model_step(2, 8, 0, 0, mexp);
    do_sample(2, 8, 0, 0, 0, 0, 1'b0, "after_rst_p", uo);
    chk("after_rst_p_u", uo, 2);
    model_step(1, 0, 8, 0, mexp);
    do_sample(1, 0, 8, 0, 0, 0, 1'b0, "after_rst_i", uo);
    chk("after_rst_i_u", uo, 3);

    // Stall during MUL_I with sample_valid held high throughout the busy period
    model_step(12, 8, 0, 0, mexp);
    do_sample(12, 8, 0, 0, 8, 5, 1'b1, "stall", uo);
    chk("stall_u", uo, 12);

    // Random samples against the reference model
    for (int n = 0; n < 30; n++) begin
      ev = int'($urandom_range(63)) - 32;
      kp = int'($urandom_range(63));
      ki = int'($urandom_range(63));
      kd = int'($urandom_range(63));
      if ($urandom_range(2) == 0) begin
        sa = int'($urandom_range(18, 2));
        sl = int'($urandom_range(3, 1));
      end else begin
        sa = 0;
        sl = 0;
      end
      hold = 1'($urandom_range(1));
      model_step(ev, kp, ki, kd, mexp);
      do_sample(ev, kp, ki, kd, sa, sl, hold, $sformatf("rnd%0d", n), uo);
      chk($sformatf("rnd%0d_u", n), uo, mexp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
